ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_rd_packer.sv | 60 ++++++
 rtl/ccff_chain_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared state enum, default chain sizing and width helper
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int CHAIN_LEN_DEF = 16;
    localparam int WORD_W_DEF    = 8;

    // Counter width that never collapses to zero bits for tiny parameters
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ccff_rd_packer.sv
// rtl/ccff_rd_packer.sv - serial-to-word readback packer with a one-word holding register
module ccff_rd_packer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_capture,
    input  logic              i_bit,
    input  logic              i_last,
    input  logic              i_rd_ready,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_block
);

    localparam int CW = clog2_min1(WORD_W);

    logic [WORD_W-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic [WORD_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_complete;
    logic [WORD_W-1:0] w_next_acc;

    assign w_complete = i_last || (r_cnt == CW'(WORD_W - 1));
    assign w_next_acc = r_acc | (WORD_W'(i_bit) << r_cnt);
    // A completing capture needs the holding register free by the same edge
    assign o_block    = r_rd_valid && !i_rd_ready && w_complete;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (r_rd_valid && i_rd_ready) begin
                r_rd_valid <= 1'b0;
            end
            if (i_capture) begin
                if (w_complete) begin
                    r_rd_data  <= w_next_acc;
                    r_rd_valid <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_next_acc;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - loads a ccff chain from host words while packing the old contents for readback
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int WORD_W    = WORD_W_DEF
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              isol_n,
    output logic              busy,
    output logic              done
);

    localparam int BW  = clog2_min1(CHAIN_LEN + 1);
    localparam int WBW = clog2_min1(WORD_W + 1);

    state_t            r_state;
    logic [WORD_W-1:0] r_sreg;
    logic [BW-1:0]     r_bits_left;
    logic [WBW-1:0]    r_word_left;
    logic              r_cfg_ready;
    logic              r_isol_n;
    logic              r_busy;
    logic              r_done;

    state_t            w_next;
    logic              w_accept;
    logic              w_last;
    logic              w_block;
    logic              w_shift;
    logic              w_word_done;
    logic              w_rd_valid;
    logic [WBW-1:0]    w_word_len;

    assign w_accept    = cfg_valid && r_cfg_ready;
    assign w_last      = (r_bits_left == BW'(1));
    assign w_shift     = (r_state == ST_SHIFT) && !w_block;
    assign w_word_done = w_shift && (r_word_left == WBW'(1));
    // The final word only carries the bits the chain still needs
    assign w_word_len  = (32'(r_bits_left) < WORD_W) ? WBW'(r_bits_left) : WBW'(WORD_W);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_LOAD;
            ST_LOAD:  if (w_accept) w_next = ST_SHIFT;
            ST_SHIFT: if (w_word_done) w_next = w_last ? ST_DRAIN : ST_LOAD;
            ST_DRAIN: if (!w_rd_valid) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state     <= ST_IDLE;
            r_sreg      <= '0;
            r_bits_left <= '0;
            r_word_left <= '0;
            r_cfg_ready <= 1'b0;
            r_isol_n    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cfg_ready <= (w_next == ST_LOAD);
            r_isol_n    <= (w_next == ST_IDLE) || (w_next == ST_DONE);
            r_busy      <= (w_next == ST_LOAD) || (w_next == ST_SHIFT) || (w_next == ST_DRAIN);
            r_done      <= (w_next == ST_DONE);
            if (r_state == ST_IDLE && start) begin
                r_bits_left <= BW'(CHAIN_LEN);
            end
            if (r_state == ST_LOAD && w_accept) begin
                r_sreg      <= cfg_data;
                r_word_left <= w_word_len;
            end
            if (w_shift) begin
                r_sreg      <= r_sreg >> 1;
                r_bits_left <= r_bits_left - 1'b1;
                r_word_left <= r_word_left - 1'b1;
            end
        end
    end

    ccff_rd_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .i_clk      (prog_clk),
        .i_rst      (prog_reset),
        .i_capture  (w_shift),
        .i_bit      (ccff_tail),
        .i_last     (w_last),
        .i_rd_ready (rd_ready),
        .o_rd_data  (rd_data),
        .o_rd_valid (w_rd_valid),
        .o_block    (w_block)
    );

    assign cfg_ready = r_cfg_ready;
    assign ccff_head = (r_state == ST_SHIFT) && r_sreg[0];
    assign shift_en  = w_shift;
    assign rd_valid  = w_rd_valid;
    assign isol_n    = r_isol_n;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
